// File: rtl/pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// pipeline_sequencer
//   Sequences a 5-stage pipeline around the decode control unit. The core is
//   held idle until start_i, then the block drives PC / pipeline-register
//   enables, bubbles and flushes for data-memory wait states, load-use hazards
//   and taken branches. A memory access that waits too long traps into a
//   sticky ERROR state. A saturating counter tallies stall cycles.
//
// Parameters
//   MEM_TIMEOUT  max cycles spent in MEM_WAIT before ERROR (>= 1)
//   CNT_W        width of stall_cnt_o
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-low reset
//   start_i         run request, honoured in IDLE only
//   ID_Op_i         opcode of the instruction in ID
//   ID_Rs1_i        rs1 of the instruction in ID
//   ID_Rs2_i        rs2 of the instruction in ID
//   ID_BrTaken_i    branch in ID resolved taken
//   EX_MemRead_i    instruction in EX is a load
//   EX_Rd_i         rd of the instruction in EX
//   MEM_Access_i    instruction in MEM is a load/store
//   mem_ack_i       data memory completes the access this cycle
//   mem_req_o       data memory request
//   PCWrite_o       PC update enable
//   IFID_Write_o    IF/ID register enable
//   IFID_Flush_o    IF/ID clear to NOP
//   IDEX_Bubble_o   ID/EX loads control zeros
//   EXMEM_Write_o   EX/MEM register enable
//   MEMWB_Bubble_o  MEM/WB loads control zeros
//   err_o           sticky memory-timeout error
//   stall_cnt_o     cycles with PCWrite_o=0 while in RUN or MEM_WAIT
// ---------------------------------------------------------------------------
module pipeline_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [6:0]       ID_Op_i,
    input  logic [4:0]       ID_Rs1_i,
    input  logic [4:0]       ID_Rs2_i,
    input  logic             ID_BrTaken_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_Rd_i,
    input  logic             MEM_Access_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Bubble_o,
    output logic             EXMEM_Write_o,
    output logic             MEMWB_Bubble_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Wide enough to hold MEM_TIMEOUT-1 for every legal MEM_TIMEOUT >= 1.
    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic active;
    logic uses_rs2;
    logic mem_stall;
    logic load_use;

    assign active   = (state_q == RUN) || (state_q == MEM_WAIT);

    // Only R-type, store and branch formats actually read rs2.
    assign uses_rs2 = (ID_Op_i == OP_RTYPE) || (ID_Op_i == OP_STORE) ||
                      (ID_Op_i == OP_BRANCH);

    // A zero-wait access (ack in the request cycle) never freezes the pipe.
    assign mem_stall = (((state_q == RUN) && MEM_Access_i) || (state_q == MEM_WAIT))
                       && !mem_ack_i;

    assign load_use = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
                      ((EX_Rd_i == ID_Rs1_i) || ((EX_Rd_i == ID_Rs2_i) && uses_rs2));

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (MEM_Access_i && !mem_ack_i) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // An ack on the final allowed cycle still completes normally.
                if (mem_ack_i) begin
                    state_d = RUN;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = ERROR;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        mem_req_o      = 1'b0;
        PCWrite_o      = 1'b0;
        IFID_Write_o   = 1'b0;
        IFID_Flush_o   = 1'b0;
        IDEX_Bubble_o  = 1'b1;
        EXMEM_Write_o  = 1'b0;
        MEMWB_Bubble_o = 1'b1;
        err_o          = (state_q == ERROR);

        if (active) begin
            mem_req_o      = (state_q == MEM_WAIT) || MEM_Access_i;
            PCWrite_o      = 1'b1;
            IFID_Write_o   = 1'b1;
            EXMEM_Write_o  = 1'b1;
            IDEX_Bubble_o  = 1'b0;
            MEMWB_Bubble_o = 1'b0;

            if (mem_stall) begin
                // Whole front end frozen; ID/EX contents are kept because
                // EX/MEM is not written, so no bubble is inserted there.
                PCWrite_o      = 1'b0;
                IFID_Write_o   = 1'b0;
                EXMEM_Write_o  = 1'b0;
                MEMWB_Bubble_o = 1'b1;
            end else if (load_use) begin
                PCWrite_o      = 1'b0;
                IFID_Write_o   = 1'b0;
                IDEX_Bubble_o  = 1'b1;
            end else if (ID_BrTaken_i) begin
                IFID_Flush_o   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- counters
    always_comb begin
        wcnt_d = wcnt_q;
        if ((state_q == RUN) && (state_d == MEM_WAIT)) begin
            wcnt_d = '0;
        end else if ((state_q == MEM_WAIT) && !mem_ack_i && (wcnt_q != WCNT_LAST)) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (active && !PCWrite_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 3;

    // Expected control word bit order:
    // {mem_req, PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Write, MEMWB_Bubble, err}
    localparam logic [7:0] E_IDLE = 8'h0A;
    localparam logic [7:0] E_ERR  = 8'h0B;
    localparam logic [7:0] E_RUN  = 8'h64;
    localparam logic [7:0] E_LU   = 8'h0C;
    localparam logic [7:0] E_MSTL = 8'h82;
    localparam logic [7:0] E_MACK = 8'hE4;
    localparam logic [7:0] E_BR   = 8'h74;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [6:0]       ID_Op_i;
    logic [4:0]       ID_Rs1_i;
    logic [4:0]       ID_Rs2_i;
    logic             ID_BrTaken_i;
    logic             EX_MemRead_i;
    logic [4:0]       EX_Rd_i;
    logic             MEM_Access_i;
    logic             mem_ack_i;
    logic             mem_req_o;
    logic             PCWrite_o;
    logic             IFID_Write_o;
    logic             IFID_Flush_o;
    logic             IDEX_Bubble_o;
    logic             EXMEM_Write_o;
    logic             MEMWB_Bubble_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    pipeline_sequencer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .ID_Op_i       (ID_Op_i),
        .ID_Rs1_i      (ID_Rs1_i),
        .ID_Rs2_i      (ID_Rs2_i),
        .ID_BrTaken_i  (ID_BrTaken_i),
        .EX_MemRead_i  (EX_MemRead_i),
        .EX_Rd_i       (EX_Rd_i),
        .MEM_Access_i  (MEM_Access_i),
        .mem_ack_i     (mem_ack_i),
        .mem_req_o     (mem_req_o),
        .PCWrite_o     (PCWrite_o),
        .IFID_Write_o  (IFID_Write_o),
        .IFID_Flush_o  (IFID_Flush_o),
        .IDEX_Bubble_o (IDEX_Bubble_o),
        .EXMEM_Write_o (EXMEM_Write_o),
        .MEMWB_Bubble_o(MEMWB_Bubble_o),
        .err_o         (err_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        int         id;
        logic [7:0] ctrl;
        logic [2:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;
    bit   stim_done = 1'b0;

    // One cycle of stimulus: inputs change just after the rising edge and the
    // hand-computed response for this cycle goes into the scoreboard.
    task automatic step(input logic rst, input logic st, input logic [6:0] op,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                        input logic mr, input logic [4:0] rd, input logic macc,
                        input logic ack, input logic [7:0] e_ctrl, input logic [2:0] e_cnt);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i        = rst;
        start_i      = st;
        ID_Op_i      = op;
        ID_Rs1_i     = rs1;
        ID_Rs2_i     = rs2;
        ID_BrTaken_i = br;
        EX_MemRead_i = mr;
        EX_Rd_i      = rd;
        MEM_Access_i = macc;
        mem_ack_i    = ack;
        e.id   = vec_id;
        e.ctrl = e_ctrl;
        e.cnt  = e_cnt;
        exp_q.push_back(e);
        vec_id++;
    endtask

    task automatic idle_step(input logic rst, input logic st, input logic [7:0] e, input logic [2:0] c);
        step(rst, st, OP_I, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, e, c);
    endtask

    task automatic mem_step(input logic macc, input logic ack, input logic br,
                            input logic [7:0] e, input logic [2:0] c);
        step(1'b1, 1'b0, OP_I, 5'd0, 5'd0, br, 1'b0, 5'd0, macc, ack, e, c);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response;
    // it is sampled mid-cycle and compared against the oldest expectation.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] got;
            e   = exp_q.pop_front();
            got = {mem_req_o, PCWrite_o, IFID_Write_o, IFID_Flush_o,
                   IDEX_Bubble_o, EXMEM_Write_o, MEMWB_Bubble_o, err_o};
            n_checks++;
            if (got !== e.ctrl) begin
                n_fail++;
                $display("FAIL vec%0d ctrl: got %b want %b", e.id, got, e.ctrl);
            end
            n_checks++;
            if (stall_cnt_o !== e.cnt) begin
                n_fail++;
                $display("FAIL vec%0d stall_cnt: got %0d want %0d", e.id, stall_cnt_o, e.cnt);
            end
        end
    end

    initial begin
        rst_i = 1'b0; start_i = 1'b0; ID_Op_i = OP_I; ID_Rs1_i = '0; ID_Rs2_i = '0;
        ID_BrTaken_i = 1'b0; EX_MemRead_i = 1'b0; EX_Rd_i = '0;
        MEM_Access_i = 1'b0; mem_ack_i = 1'b0;

        // Reset and idle hold, then start.
        idle_step(1'b0, 1'b0, E_IDLE, 3'd0);
        for (int i = 0; i < 5; i++) idle_step(1'b1, 1'b0, E_IDLE, 3'd0);
        idle_step(1'b1, 1'b1, E_IDLE, 3'd0);
        idle_step(1'b1, 1'b0, E_RUN, 3'd0);

        // Load-use on rs2 of an R-type, then the same with rd=0.
        step(1'b1, 1'b0, OP_R, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, E_LU, 3'd0);
        idle_step(1'b1, 1'b0, E_RUN, 3'd1);
        step(1'b1, 1'b0, OP_R, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, E_RUN, 3'd1);
        // rs1 match with an I-type stalls; rs2 match with an I-type does not.
        step(1'b1, 1'b0, OP_I, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, E_LU, 3'd1);
        step(1'b1, 1'b0, OP_I, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, E_RUN, 3'd2);
        // Register match but EX is not a load.
        step(1'b1, 1'b0, OP_R, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, E_RUN, 3'd2);

        // Taken branch suppressed by load-use, then taken.
        step(1'b1, 1'b0, OP_R, 5'd0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, E_LU, 3'd2);
        step(1'b1, 1'b0, OP_R, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, E_BR, 3'd3);
        idle_step(1'b1, 1'b0, E_RUN, 3'd3);

        // Wait-stated access (with a branch suppressed), ack after 3 cycles.
        mem_step(1'b1, 1'b0, 1'b1, E_MSTL, 3'd3);
        mem_step(1'b1, 1'b0, 1'b0, E_MSTL, 3'd4);
        mem_step(1'b1, 1'b0, 1'b0, E_MSTL, 3'd5);
        mem_step(1'b1, 1'b1, 1'b0, E_MACK, 3'd6);
        idle_step(1'b1, 1'b0, E_RUN, 3'd6);
        // Zero-wait access.
        mem_step(1'b1, 1'b1, 1'b0, E_MACK, 3'd6);
        idle_step(1'b1, 1'b0, E_RUN, 3'd6);

        // Sustained load-use: counter saturates at 7.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, OP_R, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, E_LU,
                 (i == 0) ? 3'd6 : 3'd7);
        idle_step(1'b1, 1'b0, E_RUN, 3'd7);

        // Timeout: 4 MEM_WAIT cycles without ack -> sticky ERROR.
        mem_step(1'b1, 1'b0, 1'b0, E_MSTL, 3'd7);
        for (int i = 0; i < 4; i++) mem_step(1'b0, 1'b0, 1'b0, E_MSTL, 3'd7);
        idle_step(1'b1, 1'b1, E_ERR, 3'd7);
        mem_step(1'b1, 1'b0, 1'b0, E_ERR, 3'd7);
        // Asynchronous reset out of ERROR, visible before any clock edge.
        idle_step(1'b0, 1'b0, E_IDLE, 3'd0);
        idle_step(1'b1, 1'b1, E_IDLE, 3'd0);
        idle_step(1'b1, 1'b0, E_RUN, 3'd0);

        // Ack on the last allowed MEM_WAIT cycle wins over the timeout.
        mem_step(1'b1, 1'b0, 1'b0, E_MSTL, 3'd0);
        for (int i = 0; i < 3; i++) mem_step(1'b1, 1'b0, 1'b0, E_MSTL, 3'(i + 1));
        mem_step(1'b1, 1'b1, 1'b0, E_MACK, 3'd4);
        idle_step(1'b1, 1'b0, E_RUN, 3'd4);

        // Asynchronous reset in the middle of MEM_WAIT.
        mem_step(1'b1, 1'b0, 1'b0, E_MSTL, 3'd4);
        mem_step(1'b1, 1'b0, 1'b0, E_MSTL, 3'd5);
        idle_step(1'b0, 1'b0, E_IDLE, 3'd0);
        idle_step(1'b1, 1'b0, E_IDLE, 3'd0);

        @(posedge clk_i);
        stim_done = 1'b1;
    end

    initial begin
        fork
            wait (stim_done && exp_q.size() == 0);
            #20000;
        join_any
        disable fork;
        n_checks++;
        if (!stim_done || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
